// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns "$<S|B|C|M>[digits]<CR|LF>" frames from the UART receiver into
// one-cycle control pulses and a mode register. Define ERR_CNT_EN to build the frame-error counter.
module uart_cmd_decoder #(
  parameter int unsigned CLK_HZ     = 32'd100_000_000,
  parameter int unsigned TIMEOUT_MS = 32'd10,
  parameter int unsigned MODE_MAX   = 32'd99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       strike_pulse,
  output logic       ball_pulse,
  output logic       clear_pulse,
  output logic [6:0] mode_val,
  output logic       mode_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int unsigned TO_CYCLES = (CLK_HZ / 32'd1000) * TIMEOUT_MS;
  localparam int unsigned TO_W      = (TO_CYCLES > 32'd2) ? $clog2(TO_CYCLES) : 32'd1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYCLES - 32'd1);
  localparam logic [6:0]      MODE_LIM = 7'(MODE_MAX);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_S      = 8'h53;
  localparam logic [7:0] CH_B      = 8'h42;
  localparam logic [7:0] CH_C      = 8'h43;
  localparam logic [7:0] CH_M      = 8'h4D;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ARG    = 3'd2,
    ST_TERM   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_S = 2'd0,
    CMD_B = 2'd1,
    CMD_C = 2'd2,
    CMD_M = 2'd3
  } cmd_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_LF) || (b == CH_CR);
  endfunction

  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [6:0]      acc_q, acc_d;
  logic            ndig_q, ndig_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [6:0]      mode_val_q, mode_val_d;
  logic            strike_q, strike_d;
  logic            ball_q, ball_d;
  logic            clear_q, clear_d;
  logic            mode_valid_q, mode_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            in_frame;

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_ARG) || (state_q == ST_TERM);

  // Next-state, accumulator, timeout and output-pulse decode
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    acc_d        = acc_q;
    ndig_d       = ndig_q;
    to_d         = to_q;
    mode_val_d   = mode_val_q;
    strike_d     = 1'b0;
    ball_d       = 1'b0;
    clear_d      = 1'b0;
    mode_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // COMMIT fires its pulse whether or not a new byte lands in the same cycle
    if (state_q == ST_COMMIT) begin
      state_d = ST_IDLE;
      case (cmd_q)
        CMD_S: strike_d = 1'b1;
        CMD_B: ball_d   = 1'b1;
        CMD_C: clear_d  = 1'b1;
        CMD_M: begin
          if (acc_q > MODE_LIM) begin
            frame_err_d = 1'b1;
          end else begin
            mode_val_d   = acc_q;
            mode_valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    if (rx_done) begin
      to_d = '0;
      case (state_q)
        ST_IDLE, ST_COMMIT: begin
          state_d = (rx_data == CH_DOLLAR) ? ST_CMD : ST_IDLE;
        end
        ST_CMD: begin
          case (rx_data)
            CH_S: begin
              cmd_d   = CMD_S;
              state_d = ST_TERM;
            end
            CH_B: begin
              cmd_d   = CMD_B;
              state_d = ST_TERM;
            end
            CH_C: begin
              cmd_d   = CMD_C;
              state_d = ST_TERM;
            end
            CH_M: begin
              cmd_d   = CMD_M;
              acc_d   = 7'd0;
              ndig_d  = 1'b0;
              state_d = ST_ARG;
            end
            CH_DOLLAR: begin
              frame_err_d = 1'b1;
              acc_d       = 7'd0;
              ndig_d      = 1'b0;
              state_d     = ST_CMD;
            end
            default: begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
            end
          endcase
        end
        ST_ARG: begin
          if (is_digit(rx_data)) begin
            acc_d   = (acc_q * 7'd10) + {3'b000, rx_data[3:0]};
            ndig_d  = 1'b1;
            state_d = ndig_q ? ST_TERM : ST_ARG;
          end else if (is_term(rx_data) && ndig_q) begin
            state_d = ST_COMMIT;
          end else if (rx_data == CH_DOLLAR) begin
            frame_err_d = 1'b1;
            acc_d       = 7'd0;
            ndig_d      = 1'b0;
            state_d     = ST_CMD;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_TERM: begin
          if (is_term(rx_data)) begin
            state_d = ST_COMMIT;
          end else if (rx_data == CH_DOLLAR) begin
            frame_err_d = 1'b1;
            acc_d       = 7'd0;
            ndig_d      = 1'b0;
            state_d     = ST_CMD;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (in_frame) begin
      if (to_q == TO_LAST) begin
        to_d        = '0;
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_S;
      acc_q        <= 7'd0;
      ndig_q       <= 1'b0;
      to_q         <= '0;
      mode_val_q   <= 7'd0;
      strike_q     <= 1'b0;
      ball_q       <= 1'b0;
      clear_q      <= 1'b0;
      mode_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      acc_q        <= acc_d;
      ndig_q       <= ndig_d;
      to_q         <= to_d;
      mode_val_q   <= mode_val_d;
      strike_q     <= strike_d;
      ball_q       <= ball_d;
      clear_q      <= clear_d;
      mode_valid_q <= mode_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = (frame_err_d && (err_cnt_q != 8'hFF)) ? (err_cnt_q + 8'd1) : err_cnt_q;

  // Saturating frame-error counter, updated alongside the frame_err pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign strike_pulse = strike_q;
  assign ball_pulse   = ball_q;
  assign clear_pulse  = clear_q;
  assign mode_val     = mode_val_q;
  assign mode_valid   = mode_valid_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule
